// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with {Z,V,N} flag register and sticky HLT state; one-cycle latency, stall holds, flush bubbles.
// Define FLAG_BYPASS_EN to drive flags from the combinational next-flag value instead of the flag register.
module ex_mem_flag_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_ovfl,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  output logic          mem_valid,
  output logic [3:0]    mem_opcode,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic [2:0]    flags,
  output logic          halted
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [0:0]    state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  logic [3:0]    mem_opcode_q, mem_opcode_d;
  logic [DW-1:0] mem_result_q, mem_result_d;
  logic [DW-1:0] mem_store_data_q, mem_store_data_d;
  logic [RW-1:0] mem_rd_q, mem_rd_d;
  logic          mem_reg_write_q, mem_reg_write_d;
  logic          mem_mem_read_q, mem_mem_read_d;
  logic          mem_mem_write_q, mem_mem_write_d;
  logic [2:0]    flags_q, flags_d;

  logic capture;
  logic res_zero;

  assign capture  = !stall && !flush && (state_q == ST_RUN);
  assign res_zero = (ex_result == '0);

  // Flush beats stall; once halted only the valid bit moves (to 0) until reset.
  always_comb begin
    state_d          = state_q;
    mem_valid_d      = mem_valid_q;
    mem_opcode_d     = mem_opcode_q;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    if (flush) begin
      mem_valid_d     = 1'b0;
      mem_reg_write_d = 1'b0;
      mem_mem_read_d  = 1'b0;
      mem_mem_write_d = 1'b0;
    end else if (state_q == ST_HALTED) begin
      mem_valid_d = 1'b0;
    end else if (!stall) begin
      mem_valid_d      = ex_valid;
      mem_opcode_d     = ex_opcode;
      mem_result_d     = ex_result;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
      mem_reg_write_d  = ex_reg_write;
      mem_mem_read_d   = ex_mem_read;
      mem_mem_write_d  = ex_mem_write;
      if (ex_valid && (ex_opcode == OP_HLT)) begin
        state_d = ST_HALTED;
      end
    end
  end

  // Z is taken from the already-saturated result, so 0x7FFF with ovfl gives Z=0.
  always_comb begin
    flags_d = flags_q;
    if (capture && ex_valid) begin
      case (ex_opcode)
        OP_ADD, OP_SUB:                 flags_d = {res_zero, ex_ovfl, ex_result[DW-1]};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[2] = res_zero;
        default:                        flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      mem_valid_q      <= 1'b0;
      mem_opcode_q     <= '0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      flags_q          <= '0;
    end else begin
      state_q          <= state_d;
      mem_valid_q      <= mem_valid_d;
      mem_opcode_q     <= mem_opcode_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      flags_q          <= flags_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_opcode     = mem_opcode_q;
  assign mem_result     = mem_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign halted         = (state_q == ST_HALTED);

`ifdef FLAG_BYPASS_EN
  assign flags = flags_d;
`else
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: spec-level model compared every cycle plus literal spot checks.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_ovfl, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_result, ex_store_data;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, halted;
  logic [3:0]  mem_opcode, mem_rd;
  logic [15:0] mem_result, mem_store_data;
  logic [2:0]  flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_flag_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .flags(flags), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flag rule straight from the opcode table: {Z,V,N}.
  function automatic logic [2:0] flag_rule(input logic [3:0] op, input logic [15:0] r,
                                           input logic ov, input logic [2:0] old);
    logic [2:0] f;
    f = old;
    if (op == 4'd0 || op == 4'd1) f = {r == 16'h0, ov, r[15]};
    else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) f = {r == 16'h0, old[1:0]};
    return f;
  endfunction

  // Model of the architectural contents of the stage.
  logic        m_valid, m_rw, m_mr, m_mw, m_halt;
  logic [3:0]  m_op, m_rd;
  logic [15:0] m_res, m_sd;
  logic [2:0]  m_flags;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_halt} = '0;
      m_op = '0; m_rd = '0; m_res = '0; m_sd = '0; m_flags = '0;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw} = '0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      if (ex_valid) m_flags = flag_rule(ex_opcode, ex_result, ex_ovfl, m_flags);
      if (ex_valid && ex_opcode == 4'hF) m_halt = 1'b1;
      m_valid = ex_valid; m_op = ex_opcode; m_res = ex_result; m_sd = ex_store_data;
      m_rd = ex_rd; m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
    end
    chk_en = 1'b1;
  end

  function automatic logic [2:0] exp_flags_out();
`ifdef FLAG_BYPASS_EN
    if (!flush && !stall && !m_halt && ex_valid)
      return flag_rule(ex_opcode, ex_result, ex_ovfl, m_flags);
`endif
    return m_flags;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mem_valid", 32'(mem_valid), 32'(m_valid));
      check("cyc_mem_opcode", 32'(mem_opcode), 32'(m_op));
      check("cyc_mem_result", 32'(mem_result), 32'(m_res));
      check("cyc_mem_store_data", 32'(mem_store_data), 32'(m_sd));
      check("cyc_mem_rd", 32'(mem_rd), 32'(m_rd));
      check("cyc_ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'({m_rw, m_mr, m_mw}));
      check("cyc_flags", 32'(flags), 32'(exp_flags_out()));
      check("cyc_halted", 32'(halted), 32'(m_halt));
    end
  end

  task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic ov,
                       input logic [15:0] sd, input logic [3:0] rd, input logic [2:0] ctl,
                       input logic vld);
    ex_opcode = op; ex_result = res; ex_ovfl = ov; ex_store_data = sd; ex_rd = rd;
    {ex_reg_write, ex_mem_read, ex_mem_write} = ctl; ex_valid = vld;
  endtask

  // One clock edge; afterwards drop ex_valid so forwarded flags show the register.
  task automatic step();
    @(posedge clk);
    #2;
    ex_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(4'h0, 16'h0, 1'b0, 16'h0, 4'h0, 3'b000, 1'b0);
    step(); step();
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_mem_result", 32'(mem_result), 32'h0);
    rst = 1'b0;

    drive(4'h0, 16'h0000, 1'b0, 16'h1234, 4'h3, 3'b100, 1'b1);
    step();
    check("add0_flags", 32'(flags), 32'b100);
    check("add0_mem_result", 32'(mem_result), 32'h0);
    check("add0_mem_valid", 32'(mem_valid), 32'h1);
    check("add0_store", 32'(mem_store_data), 32'h1234);

    drive(4'h1, 16'h8000, 1'b1, 16'h0, 4'h4, 3'b100, 1'b1);
    step();
    check("sub_sat_flags", 32'(flags), 32'b011);
    drive(4'h2, 16'h0000, 1'b0, 16'h0, 4'h4, 3'b100, 1'b1);
    step();
    check("xor_flags", 32'(flags), 32'b111);
    drive(4'h0, 16'h7FFF, 1'b1, 16'h0, 4'h4, 3'b100, 1'b1);
    step();
    check("add_7fff_flags", 32'(flags), 32'b010);
    drive(4'h3, 16'h0000, 1'b0, 16'h0, 4'h4, 3'b100, 1'b1);
    step();
    check("other_op_flags", 32'(flags), 32'b010);
    drive(4'h0, 16'h0000, 1'b0, 16'h0, 4'h2, 3'b010, 1'b0);
    step();
    check("invalid_cap_valid", 32'(mem_valid), 32'h0);
    check("invalid_cap_flags", 32'(flags), 32'b010);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 16'h0AAA + 16'(i) * 16'h0111, 1'b0, 16'h9999, 4'(i + 8), 3'b111, 1'b1);
      step();
      check("stall_mem_result", 32'(mem_result), 32'h0);
      check("stall_mem_rd", 32'(mem_rd), 32'h2);
      check("stall_flags", 32'(flags), 32'b010);
    end
    stall = 1'b0;
    drive(4'h0, 16'h8001, 1'b0, 16'h5555, 4'h5, 3'b100, 1'b1);
    step();
    check("release_mem_result", 32'(mem_result), 32'h8001);
    check("release_mem_rd", 32'(mem_rd), 32'h5);
    check("release_flags", 32'(flags), 32'b001);

    stall = 1'b1; flush = 1'b1;
    drive(4'h0, 16'h0000, 1'b0, 16'h0, 4'h6, 3'b100, 1'b1);
    step();
    check("sf_mem_valid", 32'(mem_valid), 32'h0);
    check("sf_mem_reg_write", 32'(mem_reg_write), 32'h0);
    check("sf_flags", 32'(flags), 32'b001);
    check("sf_store", 32'(mem_store_data), 32'h5555);
    stall = 1'b0; flush = 1'b0;

    drive(4'h0, 16'h0001, 1'b0, 16'h0, 4'h1, 3'b100, 1'b1);
    #1;
`ifdef FLAG_BYPASS_EN
    check("bypass_same_cycle", 32'(flags), 32'b000);
`else
    check("nobypass_pre_edge", 32'(flags), 32'b001);
`endif
    step();
    check("post_edge_flags", 32'(flags), 32'b000);

    flush = 1'b1;
    drive(4'hF, 16'h0, 1'b0, 16'h0, 4'h7, 3'b000, 1'b1);
    step();
    check("hlt_flushed_valid", 32'(mem_valid), 32'h0);
    check("hlt_flushed_halted", 32'(halted), 32'h0);
    flush = 1'b0;
    drive(4'hF, 16'h0, 1'b0, 16'h0, 4'h7, 3'b000, 1'b1);
    step();
    check("hlt_mem_valid", 32'(mem_valid), 32'h1);
    check("hlt_mem_opcode", 32'(mem_opcode), 32'hF);
    for (int i = 0; i < 2; i++) begin
      drive(4'h0, 16'h0003, 1'b0, 16'h0, 4'h9, 3'b100, 1'b1);
      step();
      check("halted_flag", 32'(halted), 32'h1);
      check("halted_mem_valid", 32'(mem_valid), 32'h0);
      check("halted_mem_opcode", 32'(mem_opcode), 32'hF);
    end

    rst = 1'b1; stall = 1'b1;
    step();
    check("rst2_halted", 32'(halted), 32'h0);
    check("rst2_mem_opcode", 32'(mem_opcode), 32'h0);
    check("rst2_mem_rd", 32'(mem_rd), 32'h0);
    check("rst2_flags", 32'(flags), 32'h0);
    rst = 1'b0; stall = 1'b0;
    drive(4'h0, 16'h0005, 1'b0, 16'h0, 4'h1, 3'b100, 1'b1);
    step();
    check("after_rst_valid", 32'(mem_valid), 32'h1);
    check("after_rst_result", 32'(mem_result), 32'h5);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
